// File: rtl/pwm_gate_driver_if.sv
// Control/status bundle between the soft-start sequencer (master) and the
// PWM gate driver (slave).
interface pwm_gate_driver_if;
    logic       i_enable;
    logic [7:0] i_duty_sel;
    logic       o_gate_hi;
    logic       o_gate_lo;
    logic       o_period_start;
    logic [7:0] o_duty_applied;

    modport master (
        output i_enable,
        output i_duty_sel,
        input  o_gate_hi,
        input  o_gate_lo,
        input  o_period_start,
        input  o_duty_applied
    );

    modport slave (
        input  i_enable,
        input  i_duty_sel,
        output o_gate_hi,
        output o_gate_lo,
        output o_period_start,
        output o_duty_applied
    );
endinterface

// File: rtl/pwm_gate_driver.sv
// Complementary PWM gate driver: period-buffered duty, dead-time window
// opened by every raw PWM edge so the two gates never conduct together.
module pwm_gate_driver #(
    parameter logic [7:0] PERIOD    = 8'd200,
    parameter logic [3:0] DEAD_TIME = 4'd4
) (
    input  logic               i_clk,
    input  logic               reset,
    pwm_gate_driver_if.slave   bus
);

    localparam logic [7:0] LAST_CNT = PERIOD - 8'd1;

    logic [7:0] cnt_q,  cnt_d;
    logic [7:0] duty_q, duty_d;
    logic       hi_q,   hi_d;
    logic       lo_q,   lo_d;
    logic       raw_q,  raw_d;
    logic [3:0] dt_q,   dt_d;
    logic       ps_q,   ps_d;

    logic       wrap;
    logic       raw;
    logic [7:0] duty_clamped;

    always_comb begin
        wrap         = (cnt_q == LAST_CNT);
        raw          = bus.i_enable && (cnt_q < duty_q);
        duty_clamped = (bus.i_duty_sel > PERIOD) ? PERIOD : bus.i_duty_sel;

        cnt_d  = cnt_q;
        duty_d = duty_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        raw_d  = raw_q;
        dt_d   = dt_q;
        ps_d   = bus.i_enable && wrap;

        if (!bus.i_enable) begin
            cnt_d = 8'd0;
        end else if (wrap) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        // Duty is only sampled at the wrap so a period never changes shape mid-way.
        if (!bus.i_enable || wrap) begin
            duty_d = duty_clamped;
        end

        if (!bus.i_enable) begin
            hi_d  = 1'b0;
            lo_d  = 1'b0;
            raw_d = 1'b0;
            dt_d  = 4'd0;
        end else if (raw != raw_q) begin
            hi_d  = 1'b0;
            lo_d  = 1'b0;
            raw_d = raw;
            dt_d  = 4'd1;
        end else if (dt_q < DEAD_TIME) begin
            hi_d  = 1'b0;
            lo_d  = 1'b0;
            dt_d  = dt_q + 4'd1;
        end else begin
            hi_d  = raw;
            lo_d  = !raw;
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            cnt_q  <= 8'd0;
            duty_q <= 8'd0;
            hi_q   <= 1'b0;
            lo_q   <= 1'b0;
            raw_q  <= 1'b0;
            dt_q   <= 4'd0;
            ps_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            raw_q  <= raw_d;
            dt_q   <= dt_d;
            ps_q   <= ps_d;
        end
    end

    assign bus.o_gate_hi      = hi_q;
    assign bus.o_gate_lo      = lo_q;
    assign bus.o_period_start = ps_q;
    assign bus.o_duty_applied = duty_q;

endmodule

// File: tb/tb_pwm_gate_driver.sv
// Self-checking bench for pwm_gate_driver (PERIOD=200, DEAD_TIME=4).
module tb_pwm_gate_driver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_gate_driver_if bus();

    pwm_gate_driver #(
        .PERIOD    (8'd200),
        .DEAD_TIME (4'd4)
    ) dut (
        .i_clk (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] duty;
        int         exp_d;
        int         exp_hi;
        int         exp_lo;
    } vec_t;

    vec_t vecs [8];
    int   exp_q [$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   synced = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Every clock advance also checks the no-overlap invariant.
    task automatic tick();
        @(negedge clk);
        synced = 1'b0;
        n_chk++;
        if (bus.o_gate_hi && bus.o_gate_lo) begin
            n_fail++;
            $display("FAIL gate_overlap: got hi=1 lo=1, expected never both at %0t", $time);
        end
    endtask

    task automatic sync_pulse();
        bit found;
        found = synced;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            found = bus.o_period_start;
        end
        if (!found) check("pulse_timeout", 0, 1);
        synced = found;
    endtask

    // Measures one full period starting at a period_start pulse.
    task automatic measure(output int d, output int hi_n, output int lo_n, output int len);
        bit found;
        sync_pulse();
        d    = int'(bus.o_duty_applied);
        hi_n = int'(bus.o_gate_hi);
        lo_n = int'(bus.o_gate_lo);
        len  = 1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (bus.o_period_start) begin
                found = 1'b1;
            end else begin
                hi_n += int'(bus.o_gate_hi);
                lo_n += int'(bus.o_gate_lo);
                len++;
            end
        end
        if (!found) check("period_end_timeout", 0, 1);
        synced = found;
    endtask

    function automatic int exp_hi(input int d);
        if (d == 200) return 200;
        if (d > 4)    return d - 4;
        return 0;
    endfunction

    function automatic int exp_lo(input int d);
        if (d == 0)   return 200;
        if (d == 200) return 0;
        return 196 - d;
    endfunction

    initial begin
        int d, hn, ln, len, e, first_ps;

        vecs[0] = '{8'd100, 100,  96,  96};
        vecs[1] = '{8'd3,     3,   0, 193};
        vecs[2] = '{8'd250, 200, 200,   0};
        vecs[3] = '{8'd0,     0,   0, 200};
        vecs[4] = '{8'd150, 150, 146,  46};
        vecs[5] = '{8'd5,     5,   1, 191};
        vecs[6] = '{8'd195, 195, 191,   1};
        vecs[7] = '{8'd1,     1,   0, 195};

        // Reset held with enable asserted
        rst            = 1'b1;
        bus.i_enable   = 1'b1;
        bus.i_duty_sel = 8'd100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hi",   int'(bus.o_gate_hi), 0);
            check("rst_lo",   int'(bus.o_gate_lo), 0);
            check("rst_ps",   int'(bus.o_period_start), 0);
            check("rst_duty", int'(bus.o_duty_applied), 0);
        end
        rst          = 1'b0;
        bus.i_enable = 1'b0;
        tick();
        check("disabled_duty_load", int'(bus.o_duty_applied), 100);
        bus.i_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("start_hi_e%0d", i), int'(bus.o_gate_hi), (i == 4) ? 1 : 0);
            check($sformatf("start_lo_e%0d", i), int'(bus.o_gate_lo), 0);
        end

        // Steady-state duty table
        sync_pulse();
        foreach (vecs[v]) begin
            bus.i_duty_sel = vecs[v].duty;
            measure(d, hn, ln, len);
            measure(d, hn, ln, len);
            measure(d, hn, ln, len);
            check($sformatf("tbl%0d_duty", v), d,   vecs[v].exp_d);
            check($sformatf("tbl%0d_hi",   v), hn,  vecs[v].exp_hi);
            check($sformatf("tbl%0d_lo",   v), ln,  vecs[v].exp_lo);
            check($sformatf("tbl%0d_len",  v), len, 200);
        end

        // Mid-period duty change 100 -> 150
        bus.i_duty_sel = 8'd100;
        measure(d, hn, ln, len);
        measure(d, hn, ln, len);
        check("chg_pre_duty", d, 100);
        for (int i = 0; i < 50; i++) tick();
        bus.i_duty_sel = 8'd150;
        exp_q.push_back(150);
        for (int i = 0; i < 149; i++) tick();
        check("chg_hold_duty", int'(bus.o_duty_applied), 100);
        check("chg_hold_ps",   int'(bus.o_period_start), 0);
        measure(d, hn, ln, len);
        e = exp_q.pop_front();
        check("chg_new_duty", d,  e);
        check("chg_new_hi",   hn, exp_hi(e));
        check("chg_new_lo",   ln, exp_lo(e));

        // Soft-start style ramp, 0..184 in steps of 23, ten periods each
        sync_pulse();
        for (int k = 0; k <= 90; k++) begin
            int cur_d, nxt_d;
            cur_d = (k == 0) ? 150 : 23 * ((k - 1) / 10);
            nxt_d = 23 * (k / 10);
            bus.i_duty_sel = nxt_d[7:0];
            exp_q.push_back(cur_d);
            measure(d, hn, ln, len);
            e = exp_q.pop_front();
            check($sformatf("ramp%0d_duty", k), d,   e);
            check($sformatf("ramp%0d_hi",   k), hn,  exp_hi(e));
            check($sformatf("ramp%0d_lo",   k), ln,  exp_lo(e));
            check($sformatf("ramp%0d_len",  k), len, 200);
        end

        // Disable mid-period while the high side is on, then re-enable
        bus.i_duty_sel = 8'd100;
        measure(d, hn, ln, len);
        measure(d, hn, ln, len);
        check("dis_pre_duty", d, 100);
        for (int i = 0; i < 30; i++) tick();
        check("dis_pre_hi", int'(bus.o_gate_hi), 1);
        bus.i_enable = 1'b0;
        tick();
        check("dis_hi", int'(bus.o_gate_hi), 0);
        check("dis_lo", int'(bus.o_gate_lo), 0);
        check("dis_ps", int'(bus.o_period_start), 0);
        bus.i_duty_sel = 8'd250;
        tick();
        check("dis_track_clamp", int'(bus.o_duty_applied), 200);
        bus.i_duty_sel = 8'd100;
        tick();
        check("dis_track", int'(bus.o_duty_applied), 100);
        bus.i_enable = 1'b1;
        first_ps = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (i <= 4)
                check($sformatf("reen_hi_e%0d", i), int'(bus.o_gate_hi), (i == 4) ? 1 : 0);
            if (bus.o_period_start && first_ps < 0) first_ps = i;
        end
        check("reen_first_ps", first_ps, 199);

        // Reset in the middle of operation
        rst = 1'b1;
        tick();
        check("mid_rst_hi",   int'(bus.o_gate_hi), 0);
        check("mid_rst_lo",   int'(bus.o_gate_lo), 0);
        check("mid_rst_ps",   int'(bus.o_period_start), 0);
        check("mid_rst_duty", int'(bus.o_duty_applied), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("d0_lo_e%0d", i), int'(bus.o_gate_lo), (i == 4) ? 1 : 0);
            check($sformatf("d0_hi_e%0d", i), int'(bus.o_gate_hi), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
